multdiv_ctrl: RTL and testbench

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

---
 rtl/multdiv_ctrl.sv | 144 ++++++++++++++
 tb/tb_multdiv_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: HI/LO register file and sequencer for an external multdiv_32 unit.
// States: IDLE (accepts requests and MT/MF), BUSY (unit running), REARM (one
// cycle with md_run low so the unit re-arms before the next request).
// A 6-bit watchdog aborts a BUSY operation that never strobes a result.
// Optional feature macro: DIV0_CHECK_EN -- when defined, divides by zero
// bypass the unit and return hi = dividend, lo = all ones.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high and req_op is legal; an illegal op is dropped
// without effect. req_ready is high only in IDLE.
module multdiv_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [4:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        req_ready,
   input  logic        mthi_en,
   input  logic        mtlo_en,
   input  logic [31:0] mt_data,
   input  logic        mfhi_req,
   input  logic        mflo_req,
   output logic [31:0] mf_data,
   output logic        stall,
   output logic        md_run,
   output logic [4:0]  md_op,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   input  logic        md_multwrite,
   input  logic        md_divwrite,
   input  logic [31:0] md_hi,
   input  logic [31:0] md_lo,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        timeout,
   output logic [1:0]  dbg_state
);

   localparam logic [4:0] OP_MULT  = 5'b01101;
   localparam logic [4:0] OP_MULTU = 5'b01110;
   localparam logic [4:0] OP_DIV   = 5'b01111;
   localparam logic [4:0] OP_DIVU  = 5'b10000;
   localparam logic [5:0] WD_LAST  = 6'd62;  // wd reaches 63 on the abort edge

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      REARM = 2'd2
   } state_t;

   state_t     state;
   logic [5:0] wd;
   logic       op_legal;
   logic       req_is_div;
   logic       accept;
   logic       cur_is_mult;
   logic       done_strobe;
   logic       div0_bypass;

   assign op_legal    = (req_op == OP_MULT) || (req_op == OP_MULTU) ||
                        (req_op == OP_DIV)  || (req_op == OP_DIVU);
   assign req_is_div  = (req_op == OP_DIV) || (req_op == OP_DIVU);
   assign accept      = (state == IDLE) && req_valid && op_legal;
   assign cur_is_mult = (md_op == OP_MULT) || (md_op == OP_MULTU);
   // Only the strobe of the class that was issued completes the operation.
   assign done_strobe = cur_is_mult ? md_multwrite : md_divwrite;

`ifdef DIV0_CHECK_EN
   assign div0_bypass = req_is_div && (req_b == 32'd0);
`else
   assign div0_bypass = 1'b0;
`endif

   assign req_ready = (state == IDLE);
   assign stall     = (mfhi_req | mflo_req | mthi_en | mtlo_en) & (state != IDLE);
   assign dbg_state = state;

   // MF read port: HI has priority when both reads are requested.
   always_comb begin
      mf_data = 32'd0;
      if (mfhi_req)      mf_data = hi;
      else if (mflo_req) mf_data = lo;
   end

   // Sequencer, operand latches, HI/LO registers and watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         md_run  <= 1'b0;
         md_op   <= 5'd0;
         md_a    <= 32'd0;
         md_b    <= 32'd0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         wd      <= 6'd0;
         timeout <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               // MT writes land even on an accept edge; the result overwrites later.
               if (mthi_en) hi <= mt_data;
               if (mtlo_en) lo <= mt_data;
               if (accept) begin
                  if (div0_bypass) begin
                     hi    <= req_a;
                     lo    <= 32'hFFFF_FFFF;
                     state <= REARM;
                  end else begin
                     md_op  <= req_op;
                     md_a   <= req_a;
                     md_b   <= req_b;
                     wd     <= 6'd0;
                     md_run <= 1'b1;
                     state  <= BUSY;
                  end
               end
            end
            BUSY: begin
               wd <= wd + 6'd1;
               if (done_strobe) begin
                  hi     <= md_hi;
                  lo     <= md_lo;
                  md_run <= 1'b0;
                  state  <= REARM;
               end else if (wd == WD_LAST) begin
                  md_run  <= 1'b0;
                  timeout <= 1'b1;
                  state   <= REARM;
               end
            end
            REARM: begin
               state <= IDLE;
            end
            default: begin
               md_run <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: bench for multdiv_ctrl. The bench plays the role of the
// multdiv_32 unit and checks HI/LO against arithmetic computed here.
module tb_multdiv_ctrl;

   localparam logic [4:0] OP_MULT  = 5'b01101;
   localparam logic [4:0] OP_MULTU = 5'b01110;
   localparam logic [4:0] OP_DIV   = 5'b01111;
   localparam logic [4:0] OP_DIVU  = 5'b10000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [4:0]  req_op;
   logic [31:0] req_a, req_b;
   logic        req_ready;
   logic        mthi_en, mtlo_en;
   logic [31:0] mt_data;
   logic        mfhi_req, mflo_req;
   logic [31:0] mf_data;
   logic        stall, md_run;
   logic [4:0]  md_op;
   logic [31:0] md_a, md_b;
   logic        md_multwrite, md_divwrite;
   logic [31:0] md_hi, md_lo;
   logic [31:0] hi, lo;
   logic        timeout;
   logic [1:0]  dbg_state;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model_hi, model_lo;
   logic [4:0]  model_op;
   logic [31:0] model_a, model_b;

   multdiv_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .mthi_en(mthi_en), .mtlo_en(mtlo_en), .mt_data(mt_data),
      .mfhi_req(mfhi_req), .mflo_req(mflo_req), .mf_data(mf_data),
      .stall(stall), .md_run(md_run), .md_op(md_op), .md_a(md_a), .md_b(md_b),
      .md_multwrite(md_multwrite), .md_divwrite(md_divwrite),
      .md_hi(md_hi), .md_lo(md_lo), .hi(hi), .lo(lo),
      .timeout(timeout), .dbg_state(dbg_state)
   );

   // Clock and global time limit
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running, required to finish");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // MIPS-style result: {hi, lo} = 64-bit product, or {remainder, quotient}.
   function automatic logic [63:0] ref_result(input logic [4:0] op,
                                               input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic signed [31:0] sa, sb;
      ref_result = 64'd0;
      sa = a;
      sb = b;
      case (op)
         OP_MULT: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            ref_result = sp;
         end
         OP_MULTU: ref_result = {32'd0, a} * {32'd0, b};
         OP_DIV:  if (b == 0) ref_result = {a, 32'hFFFF_FFFF};
                  else ref_result = {sa % sb, sa / sb};
         OP_DIVU: if (b == 0) ref_result = {a, 32'hFFFF_FFFF};
                  else ref_result = {a % b, a / b};
         default: ref_result = 64'd0;
      endcase
   endfunction

   task automatic idle_inputs();
      req_valid = 0; req_op = 0; req_a = 0; req_b = 0;
      mthi_en = 0; mtlo_en = 0; mt_data = 0; mfhi_req = 0; mflo_req = 0;
      md_multwrite = 0; md_divwrite = 0; md_hi = 0; md_lo = 0;
   endtask

   // Checks everything that reset must force to zero; call while rst is high.
   task automatic check_reset_state(input string tag);
      check({tag, "_md_run"}, md_run, 0);
      check({tag, "_md_op"}, md_op, 0);
      check({tag, "_md_a"}, md_a, 0);
      check({tag, "_md_b"}, md_b, 0);
      check({tag, "_hi"}, hi, 0);
      check({tag, "_lo"}, lo, 0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_stall"}, stall, 0);
      check({tag, "_ready"}, req_ready, 1);
   endtask

   // Issue one legal op, act as the unit, and check the whole sequence.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_hi, input logic [31:0] e_lo,
                         input int delay, input bit wrong, input bit mf_hold, input bit mt_with);
      logic [31:0] mt_val;
      logic [63:0] unit_r;
      bit          is_mult;
      is_mult = (op == OP_MULT) || (op == OP_MULTU);
      @(negedge clk);
      req_valid = 1; req_op = op; req_a = a; req_b = b;
      mt_val = $urandom;
      if (mt_with) begin mthi_en = 1; mt_data = mt_val; end
      exp_q.push_back(e_hi);
      exp_q.push_back(e_lo);
      #1 check("ready_idle", req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 0; mthi_en = 0;
      model_op = op; model_a = a; model_b = b;
      mfhi_req = mf_hold;
      #1;
      if (mt_with) begin
         model_hi = mt_val;
         check("mt_with_req", hi, mt_val);
      end
      check("md_op", md_op, op);
      check("md_a", md_a, a);
      check("md_b", md_b, b);
      check("ready_busy", req_ready, 0);
      for (int i = 0; i < delay; i++) begin
         check("run_busy", md_run, 1);
         if (mf_hold) check("stall_busy", stall, 1);
         if (wrong && i == 0) begin
            md_hi = $urandom; md_lo = $urandom;
            if (is_mult) md_divwrite = 1; else md_multwrite = 1;
         end
         @(negedge clk);
         md_multwrite = 0; md_divwrite = 0;
         #1;
      end
      check("run_busy", md_run, 1);
      unit_r = ref_result(md_op, md_a, md_b);
      md_hi = unit_r[63:32]; md_lo = unit_r[31:0];
      if (is_mult) md_multwrite = 1; else md_divwrite = 1;
      @(negedge clk);
      md_multwrite = 0; md_divwrite = 0; md_hi = $urandom; md_lo = $urandom;
      #1;
      model_hi = exp_q.pop_front();
      model_lo = exp_q.pop_front();
      check("hi_result", hi, model_hi);
      check("lo_result", lo, model_lo);
      check("run_rearm", md_run, 0);
      check("ready_rearm", req_ready, 0);
      check("timeout_rearm", timeout, 0);
      if (mf_hold) check("stall_rearm", stall, 1);
      @(negedge clk);
      #1;
      check("ready_back", req_ready, 1);
      check("stall_idle", stall, 0);
      if (mf_hold) check("mf_new_hi", mf_data, model_hi);
      mfhi_req = 0;
   endtask

   // Op issued, unit never answers: watchdog must abort with HI/LO intact.
   task automatic run_timeout();
      int cnt;
      @(negedge clk);
      mthi_en = 1; mt_data = 32'h1234_5678;
      @(negedge clk);
      mthi_en = 0;
      model_hi = 32'h1234_5678;
      #1 check("mthi_pre", hi, 32'h1234_5678);
      req_valid = 1; req_op = OP_DIVU; req_a = 100; req_b = 7;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      mtlo_en = 1; mt_data = 32'hDEAD_BEEF;   // must be held off by the stall
      cnt = 0;
      #1 check("stall_mt", stall, 1);
      while (md_run && cnt < 100) begin
         cnt++;
         @(negedge clk);
         #1;
      end
      mtlo_en = 0;
      check("wd_cycles", cnt, 63);
      check("timeout_pulse", timeout, 1);
      check("hi_kept", hi, model_hi);
      check("lo_kept", lo, model_lo);
      @(negedge clk);
      #1;
      check("timeout_low", timeout, 0);
      check("ready_after_to", req_ready, 1);
      check("lo_after_to", lo, model_lo);
   endtask

`ifdef DIV0_CHECK_EN
   task automatic run_div0();
      @(negedge clk);
      req_valid = 1; req_op = OP_DIVU; req_a = 9; req_b = 0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      #1;
      check("div0_run", md_run, 0);
      check("div0_hi", hi, 9);
      check("div0_lo", lo, 32'hFFFF_FFFF);
      check("div0_ready_rearm", req_ready, 0);
      model_hi = 9; model_lo = 32'hFFFF_FFFF;
      @(negedge clk);
      #1;
      check("div0_run2", md_run, 0);
      check("div0_ready", req_ready, 1);
   endtask
`endif

   // Main sequence and final report
   initial begin
      logic [4:0]  ops[4];
      logic [4:0]  op, bad_op;
      logic [31:0] a, b;
      logic [63:0] r;
      ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
      idle_inputs();
      rst = 1;
      model_hi = 0; model_lo = 0; model_op = 0; model_a = 0; model_b = 0;
      #1 check_reset_state("reset");
      repeat (2) @(negedge clk);
      rst = 0;

      // Directed arithmetic cases
      run_op(OP_MULTU, 4, 5, 32'h0, 32'd20, 3, 0, 0, 0);
      run_op(OP_MULT, 32'hFFFF_FFFC, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 2, 1, 0, 0);
      run_op(OP_DIVU, 7, 2, 32'd1, 32'd3, 5, 1, 1, 0);
      run_op(OP_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 1, 1);

      // MT/MF behaviour in IDLE
      @(negedge clk);
      mthi_en = 1; mt_data = 32'hCAFE_0001; mfhi_req = 1;
      #1 check("mf_same_cycle_old", mf_data, model_hi);
      @(negedge clk);
      mthi_en = 0; model_hi = 32'hCAFE_0001;
      mtlo_en = 1; mt_data = 32'h0BAD_F00D; mflo_req = 1;
      #1 check("mf_both_gives_hi", mf_data, model_hi);
      @(negedge clk);
      mtlo_en = 0; mfhi_req = 0; model_lo = 32'h0BAD_F00D;
      #1 check("mflo_read", mf_data, model_lo);
      mflo_req = 0;

      // Illegal opcodes are dropped
      for (int k = 0; k < 4; k++) begin
         do bad_op = 5'($urandom_range(0, 31));
         while (bad_op == OP_MULT || bad_op == OP_MULTU || bad_op == OP_DIV || bad_op == OP_DIVU);
         @(negedge clk);
         req_valid = 1; req_op = bad_op; req_a = $urandom; req_b = $urandom;
         @(negedge clk);
         req_valid = 0;
         #1;
         check("illegal_ready", req_ready, 1);
         check("illegal_run", md_run, 0);
         check("illegal_md_op", md_op, model_op);
         check("illegal_md_a", md_a, model_a);
         check("illegal_hi", hi, model_hi);
         check("illegal_lo", lo, model_lo);
      end

      // Randomized legal traffic
      for (int k = 0; k < 24; k++) begin
         op = ops[$urandom_range(0, 3)];
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
         if (op == OP_DIV || op == OP_DIVU) begin
            if (b == 0 || b == 32'hFFFF_FFFF) b = 3;
         end
         r = ref_result(op, a, b);
         run_op(op, a, b, r[63:32], r[31:0], $urandom_range(0, 12),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      run_timeout();

      // Divide by zero
`ifdef DIV0_CHECK_EN
      run_div0();
`else
      run_op(OP_DIVU, 9, 0, 32'd9, 32'hFFFF_FFFF, 4, 0, 0, 0);
`endif

      // Asynchronous reset in the middle of a divide
      @(negedge clk);
      req_valid = 1; req_op = OP_DIVU; req_a = 1000; req_b = 3;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      repeat (3) @(negedge clk);
      mfhi_req = 1;
      #2 rst = 1;
      #1 check_reset_state("mid_rst");
      @(negedge clk);
      rst = 0; mfhi_req = 0;
      model_hi = 0; model_lo = 0;
      #1 check("mf_after_rst", hi, 0);
      run_op(OP_MULTU, 4, 5, 32'h0, 32'd20, 6, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
